// File: rtl/square_seq.sv
// Sequential shift-and-add squarer: one operand bit per cycle, fixed WIDTH-cycle latency.
// Valid/ready handshake on both sides; in_ready and out_valid are registered.
module square_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t               state;
    logic [WIDTH-1:0]     operand;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [IW-1:0]        bit_idx;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_bit;

    // Partial product for the current bit; never overflows since x*x < 2^(2*WIDTH).
    always_comb begin
        bit_idx  = cnt[IW-1:0];
        addend   = '0;
        if (operand[bit_idx]) begin
            addend = {{WIDTH{1'b0}}, operand} << cnt;
        end
        acc_next = acc + addend;
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            operand   <= '0;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        operand  <= in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= StCalc;
                    end
                end
                StCalc: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        out       <= acc_next;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    // out is left holding the last result after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq: accepted operands are queued, a negedge monitor
// checks each delivered result against x*x, its latency, and DONE-state stability.
module tb_square_seq;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] x_q[$];
    int           acc_q[$];
    logic [W-1:0] last_x = '0;

    square_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in(in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out)
    );

    always #5 clk = ~clk;

    function automatic longint sq(input logic [W-1:0] x);
        return longint'(x) * longint'(x);
    endfunction

    function automatic longint isqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Records accepted operands and the cycle of acceptance.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            x_q.delete();
            acc_q.delete();
        end else if (in_valid && in_ready) begin
            x_q.push_back(in);
            acc_q.push_back(cyc);
        end
    end

    logic           pv = 1'b0;
    logic           ptake = 1'b0;
    logic [2*W-1:0] pout = '0;

    always @(negedge clk) begin
        logic [W-1:0] x;
        int a;
        if (rst) begin
            pv = 1'b0;
            ptake = 1'b0;
        end else begin
            if (pv && !ptake) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_out", 64'(out), 64'(pout));
            end
            if (ptake) chk("valid_drop", 64'(out_valid), 64'd0);
            if (out_valid && !pv) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid: out_valid=1 with no operand pending (t=%0t)",
                             $time);
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", 64'(cyc - a), 64'(W));
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (x_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: out=%0d with empty scoreboard", out);
                end else begin
                    x = x_q.pop_front();
                    chk("square", 64'(out), 64'(sq(x)));
                    chk("sqrt_back", 64'(isqrt(longint'(out))), 64'(x));
                end
            end
            pv = out_valid;
            pout = out;
            ptake = out_valid && out_ready;
        end
    end

    task automatic send(input logic [W-1:0] x);
        int n = 0;
        in_valid = 1'b1;
        in = x;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for operand %0d", x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in = W'($urandom);
        last_x = x;
        chk("busy_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (x_q.size() != 0 && n < 500) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", x_q.size());
        end
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("out_kept", 64'(out), 64'(sq(last_x)));
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        // Reset with in_valid asserted must not start an operation.
        rst = 1'b1;
        in_valid = 1'b1;
        in = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);

        send(16'd0);     drain(1'b0);
        send(16'd65535); drain(1'b0);
        send(16'd46341); drain(1'b0);

        // Consumer stalls for 5 cycles in DONE.
        out_ready = 1'b0;
        send(16'd3);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        drain(1'b0);

        // Second operand offered throughout CALC/DONE of the first.
        send(16'd7);
        send(16'd9);
        drain(1'b0);

        // Reset lands on the 8th CALC edge.
        send(16'd1000);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out", 64'(out), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (25) @(posedge clk);
        #1;
        send(16'd12);
        drain(1'b0);

        send(16'd1);     drain(1'b1);
        send(16'd32768); drain(1'b1);
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom));
            drain(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/square_seq.md
SQUARE_SEQ -- requirements
Module: square_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, root/operand width; result width is 2*WIDTH.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand offered.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 The block SHALL have port in  input  WIDTH  unsigned operand (a root value, e.g. a sqrt result).
REQ-007 The block SHALL have port out_valid  output  1  result available.
REQ-008 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-009 The block SHALL have port out  output  2*WIDTH  unsigned square in*in, exact, no truncation.

Function
REQ-010 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-011 The block SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; both are registered or decoded from state only, never combinational from inputs.
REQ-012 In IDLE, an edge with in_valid=1 SHALL accept: latch operand=in, acc=0, bit counter=0, go to CALC.
REQ-013 In CALC, each edge SHALL process operand bit [counter]: if set, acc += operand << counter (2*WIDTH-bit add, no overflow possible); counter increments.
REQ-014 After the edge processing bit WIDTH-1, the block SHALL load out=acc and go to DONE; out_valid rises exactly WIDTH edges after the accepting edge, with fixed latency independent of operand value (including 0).
REQ-015 In DONE, out and out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-016 In DONE, an edge with out_ready=1 SHALL complete the handshake: go to IDLE, out_valid=0; out keeps its last value.
REQ-017 The block SHALL ignore in_valid in CALC and DONE (operand not latched, no state change); the upstream holds its operand until in_ready.
REQ-018 Minimum spacing between acceptances SHALL be WIDTH+2 edges (accept, WIDTH calc edges minus overlap, DONE handshake, IDLE).
REQ-019 Changes on in after acceptance SHALL NOT affect the result in progress.
REQ-020 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-021 With rst=1 at an edge, the block SHALL enter IDLE with out=0, out_valid=0, in_ready=1 (visible after that edge), acc=0, counter=0, operand=0.
REQ-022 rst SHALL take priority over all handshakes; reset during CALC or DONE SHALL discard the operation with no out_valid pulse.
REQ-023 in_valid=1 coincident with rst=1 SHALL NOT be accepted.

Verification
REQ-024 Reset, then in=0 accepted at edge E0, out_ready=1 -> out_valid high after E16, out=0, back to IDLE after E17.
REQ-025 in=65535 -> out=4294836225 at exactly 16 edges after acceptance; in=46341 -> out=2147488281.
REQ-026 in=3 with out_ready held 0 for 5 cycles in DONE -> out=9 and out_valid stable all 5 cycles; released on the first out_ready=1 edge.
REQ-027 in=7 accepted, then in_valid=1 with in=9 throughout CALC/DONE -> first result 49; 9 accepted only on the next IDLE, result 81.
REQ-028 in=1000 accepted, rst pulsed at the 8th CALC edge -> out=0, out_valid never asserted, in_ready=1; a new in=12 then yields 144.
REQ-029 Random sweep: for operand x, out==x*x; cross-check with sqrt block: sqrt(out)==x for all x in 0..65535 (WIDTH=16).
